// File: rtl/invaders_pkg.sv
// Shared playfield geometry, coordinate widths and controller state encoding
// for the invaders game blocks.
package invaders_pkg;

  localparam int FIELD_COLS       = 20;
  localparam int FIELD_ROWS       = 16;
  localparam int X_W              = 5;
  localparam int Y_W              = 4;
  localparam int BULLET_SPAWN_ROW = 14;
  localparam int BULLET_PARK_ROW  = 15;

  localparam logic [X_W-1:0] X_MAX     = X_W'(FIELD_COLS - 1);
  localparam logic [Y_W-1:0] Y_SPAWN   = Y_W'(BULLET_SPAWN_ROW);
  localparam logic [Y_W-1:0] Y_PARK    = Y_W'(BULLET_PARK_ROW);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    FLYING   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // Columns beyond the right edge of the field snap to the last column.
  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] x);
    logic [X_W-1:0] r;
    if (x > X_MAX) begin
      r = X_MAX;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Movement tick divider: pulses tick once every MOVE_DIV cycles while clear
// is low; shared by bullet flight and invader march timing.
module tick_div #(
  parameter int MOVE_DIV = 1800000
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOVE_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Free-running modulo-MOVE_DIV counter, held at zero while cleared.
  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      cnt_r <= CNT_W'(0);
    end else if (clear || (cnt_r == CNT_MAX)) begin
      cnt_r <= CNT_W'(0);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = ~clear & (cnt_r == CNT_MAX);

endmodule

// File: rtl/bullet_ctrl.sv
// Player bullet controller: launches, moves and retires a single bullet.
// Define BULLET_COOLDOWN_EN to add a re-arm delay of COOLDOWN_TICKS ticks.
module bullet_ctrl
  import invaders_pkg::*;
#(
  parameter int MOVE_DIV = 1800000
`ifdef BULLET_COOLDOWN_EN
  , parameter int COOLDOWN_TICKS = 4
`endif
) (
  input  logic           clk_36MHz,
  input  logic           reset,
  input  logic           start,
  input  logic           fire,
  input  logic [X_W-1:0] player_x,
  input  logic           hit,
  output logic [X_W-1:0] bullet_x,
  output logic [Y_W-1:0] bullet_y,
  output logic           bullet_active,
  output logic           shot_fired
);

`ifdef BULLET_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [CD_W-1:0] CD_MAX = CD_W'(COOLDOWN_TICKS - 1);
  localparam state_t RETIRE_ST = COOLDOWN;
  logic [CD_W-1:0] cd_cnt_r;
`else
  localparam state_t RETIRE_ST = READY;
`endif

  state_t state_r;
  logic   fire_q_r;
  logic   launch_s;
  logic   tick_s;
  logic   div_clear_s;

  assign launch_s = fire & ~fire_q_r;

  // The divider only runs while a bullet or a cooldown needs timing.
  always_comb begin
    div_clear_s = 1'b1;
    if ((state_r == FLYING) || (state_r == COOLDOWN)) begin
      div_clear_s = 1'b0;
    end else begin
      div_clear_s = 1'b1;
    end
  end

  tick_div #(
    .MOVE_DIV (MOVE_DIV)
  ) u_tick_div (
    .clk_36MHz (clk_36MHz),
    .reset     (reset),
    .clear     (div_clear_s),
    .tick      (tick_s)
  );

  // Bullet state machine with registered coordinates and launch pulse.
  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      fire_q_r      <= 1'b0;
      bullet_x      <= X_W'(0);
      bullet_y      <= Y_PARK;
      bullet_active <= 1'b0;
      shot_fired    <= 1'b0;
`ifdef BULLET_COOLDOWN_EN
      cd_cnt_r      <= CD_W'(0);
`endif
    end else begin
      fire_q_r   <= fire;
      shot_fired <= 1'b0;
      if (!start) begin
        state_r       <= IDLE;
        bullet_x      <= X_W'(0);
        bullet_y      <= Y_PARK;
        bullet_active <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r       <= READY;
            bullet_x      <= X_W'(0);
            bullet_y      <= Y_PARK;
            bullet_active <= 1'b0;
          end
          READY: begin
            if (launch_s) begin
              state_r       <= FLYING;
              bullet_x      <= clamp_x(player_x);
              bullet_y      <= Y_SPAWN;
              bullet_active <= 1'b1;
              shot_fired    <= 1'b1;
            end else begin
              state_r <= READY;
            end
          end
          FLYING: begin
            // A hit or a tick at the top row retires the bullet.
            if (hit || (tick_s && (bullet_y == Y_W'(0)))) begin
              state_r       <= RETIRE_ST;
              bullet_x      <= X_W'(0);
              bullet_y      <= Y_PARK;
              bullet_active <= 1'b0;
`ifdef BULLET_COOLDOWN_EN
              cd_cnt_r      <= CD_W'(0);
`endif
            end else if (tick_s) begin
              bullet_y <= bullet_y - Y_W'(1);
            end else begin
              state_r <= FLYING;
            end
          end
`ifdef BULLET_COOLDOWN_EN
          COOLDOWN: begin
            if (tick_s && (cd_cnt_r == CD_MAX)) begin
              state_r <= READY;
            end else if (tick_s) begin
              cd_cnt_r <= cd_cnt_r + CD_W'(1);
            end else begin
              state_r <= COOLDOWN;
            end
          end
`endif
          default: begin
            state_r       <= IDLE;
            bullet_x      <= X_W'(0);
            bullet_y      <= Y_PARK;
            bullet_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
